// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer.
// All outputs are registered. The registered values line up with the state
// shown on State. IRWrite therefore shows during the first DECODE cycle,
// which is the cycle that follows the IR latch edge.
module multicycle_control_unit #(
   parameter int EN_SLT      = 1,
   parameter int EN_JUMP     = 1,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] IWord,
   input  logic        IValid,
   input  logic        BEQ,
   input  logic        BLT,
   input  logic        MemReady,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        RegWEn,
   output logic        MemReq,
   output logic        MemRW,
   output logic        BrUn,
   output logic        ASel,
   output logic        BSel,
   output logic        PCSelect,
   output logic        Illegal,
   output logic [2:0]  ImmSel,
   output logic [1:0]  WBSel,
   output logic [3:0]  ALUOP,
   output logic [2:0]  State
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [3:0] ALU_AND   = 4'd1;
   localparam logic [3:0] ALU_OR    = 4'd2;
   localparam logic [3:0] ALU_XOR   = 4'd3;
   localparam logic [3:0] ALU_ADD   = 4'd4;
   localparam logic [3:0] ALU_SUB   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SLL   = 4'd7;
   localparam logic [3:0] ALU_SRA   = 4'd8;
   localparam logic [3:0] ALU_SLT   = 4'd9;
   localparam logic [3:0] ALU_SLTU  = 4'd10;
   localparam logic [3:0] ALU_PASSB = 4'd11;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
   localparam logic       SLT_ON    = (EN_SLT != 0);
   localparam logic       JUMP_ON   = (EN_JUMP != 0);

   state_t      state_reg;
   logic [31:0] ir_reg;
   logic [7:0]  wait_cnt_reg;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rd;
   logic       rd_nonzero;

   logic       dec_legal;
   logic [3:0] dec_aluop;
   logic [2:0] dec_immsel;
   logic [1:0] dec_wbsel;
   logic       dec_asel;
   logic       dec_bsel;
   logic       dec_brun;
   logic       dec_load;
   logic       dec_store;
   logic       dec_branch;
   logic       dec_jump;
   logic       dec_wr;
   logic       br_taken;

   // Register-source fields are not needed by the controller.
   logic unused_fields;
   assign unused_fields = ^ir_reg[24:15];

   assign opcode     = ir_reg[6:0];
   assign rd         = ir_reg[11:7];
   assign funct3     = ir_reg[14:12];
   assign funct7     = ir_reg[31:25];
   assign rd_nonzero = (rd != 5'd0);
   assign State      = state_reg;

   // Instruction decode, driven only from the latched IR.
   always_comb begin
      dec_legal  = 1'b0;
      dec_aluop  = 4'd0;
      dec_immsel = 3'd0;
      dec_wbsel  = 2'd1;
      dec_asel   = 1'b0;
      dec_bsel   = 1'b1;
      dec_brun   = 1'b0;
      dec_load   = 1'b0;
      dec_store  = 1'b0;
      dec_branch = 1'b0;
      dec_jump   = 1'b0;
      dec_wr     = 1'b0;
      case (opcode)
         OP_R, OP_I: begin
            dec_bsel = (opcode == OP_I);
            dec_wr   = 1'b1;
            // funct7 only qualifies I-type shifts; other I-ops carry immediate bits there
            dec_legal = (opcode == OP_I) || (funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
            case (funct3)
               3'd0: dec_aluop = (opcode == OP_R && funct7 == 7'h20) ? ALU_SUB : ALU_ADD;
               3'd1: begin
                  dec_aluop = ALU_SLL;
                  if (funct7 != 7'h00) dec_legal = 1'b0;
               end
               3'd2: begin
                  dec_aluop = ALU_SLT;
                  if (!SLT_ON) dec_legal = 1'b0;
               end
               3'd3: begin
                  dec_aluop = ALU_SLTU;
                  if (!SLT_ON) dec_legal = 1'b0;
               end
               3'd4: dec_aluop = ALU_XOR;
               3'd5: begin
                  dec_aluop = ir_reg[30] ? ALU_SRA : ALU_SRL;
                  if (funct7 != 7'h00 && funct7 != 7'h20) dec_legal = 1'b0;
               end
               3'd6: dec_aluop = ALU_OR;
               default: dec_aluop = ALU_AND;
            endcase
         end
         OP_LOAD: begin
            dec_legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
            dec_aluop = ALU_ADD;
            dec_wbsel = 2'd0;
            dec_load  = 1'b1;
            dec_wr    = 1'b1;
         end
         OP_STORE: begin
            dec_legal  = (funct3 <= 3'd2);
            dec_aluop  = ALU_ADD;
            dec_immsel = 3'd1;
            dec_store  = 1'b1;
         end
         OP_BRANCH: begin
            dec_legal  = (funct3 != 3'd2) && (funct3 != 3'd3);
            dec_aluop  = ALU_ADD;
            dec_immsel = 3'd2;
            dec_asel   = 1'b1;
            dec_brun   = funct3[1];
            dec_branch = 1'b1;
         end
         OP_LUI: begin
            dec_legal  = JUMP_ON;
            dec_aluop  = ALU_PASSB;
            dec_immsel = 3'd3;
            dec_wr     = 1'b1;
         end
         OP_AUIPC: begin
            dec_legal  = JUMP_ON;
            dec_aluop  = ALU_ADD;
            dec_immsel = 3'd3;
            dec_asel   = 1'b1;
            dec_wr     = 1'b1;
         end
         OP_JAL: begin
            dec_legal  = JUMP_ON;
            dec_aluop  = ALU_ADD;
            dec_immsel = 3'd4;
            dec_asel   = 1'b1;
            dec_wbsel  = 2'd2;
            dec_jump   = 1'b1;
            dec_wr     = 1'b1;
         end
         OP_JALR: begin
            dec_legal  = JUMP_ON && (funct3 == 3'd0);
            dec_aluop  = ALU_ADD;
            dec_wbsel  = 2'd2;
            dec_jump   = 1'b1;
            dec_wr     = 1'b1;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Branch outcome from comparator flags: funct3[0] inverts, funct3[2] picks BLT.
   always_comb begin
      br_taken = (funct3[2] ? BLT : BEQ) ^ funct3[0];
   end

   // Main sequencer with registered control outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= S_FETCH;
         ir_reg       <= 32'h0000_0013;
         wait_cnt_reg <= 8'd0;
         PCWrite      <= 1'b0;
         IRWrite      <= 1'b0;
         RegWEn       <= 1'b0;
         MemReq       <= 1'b0;
         MemRW        <= 1'b0;
         BrUn         <= 1'b0;
         ASel         <= 1'b0;
         BSel         <= 1'b0;
         PCSelect     <= 1'b0;
         Illegal      <= 1'b0;
         ImmSel       <= 3'd0;
         WBSel        <= 2'd0;
         ALUOP        <= 4'd0;
      end else begin
         PCWrite <= 1'b0;
         IRWrite <= 1'b0;
         RegWEn  <= 1'b0;
         case (state_reg)
            S_FETCH: begin
               BrUn     <= 1'b0;
               ASel     <= 1'b0;
               BSel     <= 1'b0;
               PCSelect <= 1'b0;
               ImmSel   <= 3'd0;
               WBSel    <= 2'd0;
               ALUOP    <= 4'd0;
               if (IValid) begin
                  ir_reg    <= IWord;
                  IRWrite   <= 1'b1;
                  state_reg <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!dec_legal) begin
                  Illegal   <= 1'b1;
                  state_reg <= S_TRAP;
               end else begin
                  ALUOP     <= dec_aluop;
                  ImmSel    <= dec_immsel;
                  WBSel     <= dec_wbsel;
                  ASel      <= dec_asel;
                  BSel      <= dec_bsel;
                  BrUn      <= dec_brun;
                  PCSelect  <= dec_branch ? br_taken : dec_jump;
                  PCWrite   <= dec_branch;
                  state_reg <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (dec_load || dec_store) begin
                  MemReq       <= 1'b1;
                  MemRW        <= dec_store;
                  wait_cnt_reg <= 8'd0;
                  state_reg    <= S_MEM;
               end else if (dec_branch) begin
                  PCSelect  <= 1'b0;
                  state_reg <= S_FETCH;
               end else begin
                  RegWEn    <= dec_wr && rd_nonzero;
                  PCWrite   <= 1'b1;
                  state_reg <= S_WB;
               end
            end
            S_MEM: begin
               if (MemReady) begin
                  MemReq  <= 1'b0;
                  MemRW   <= 1'b0;
                  PCWrite <= 1'b1;
                  if (dec_store) begin
                     state_reg <= S_FETCH;
                  end else begin
                     RegWEn    <= rd_nonzero;
                     state_reg <= S_WB;
                  end
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  MemReq    <= 1'b0;
                  MemRW     <= 1'b0;
                  Illegal   <= 1'b1;
                  state_reg <= S_TRAP;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 8'd1;
               end
            end
            S_WB: begin
               state_reg <= S_FETCH;
            end
            default: begin
               // TRAP, and any unreachable encoding, parks here until reset.
               MemReq    <= 1'b0;
               MemRW     <= 1'b0;
               Illegal   <= 1'b1;
               state_reg <= S_TRAP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one line per instruction transaction.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] IWord;
   logic        IValid, BEQ, BLT, MemReady;
   logic        PCWrite, IRWrite, RegWEn, MemReq, MemRW, BrUn, ASel, BSel, PCSelect, Illegal;
   logic [2:0]  ImmSel, State;
   logic [1:0]  WBSel;
   logic [3:0]  ALUOP;

   logic        n_pcw, n_irw, n_rwe, n_mrq, n_mrw, n_bru, n_asel, n_bsel, n_pcs, n_ill;
   logic [2:0]  n_imm, n_state;
   logic [1:0]  n_wb;
   logic [3:0]  n_alu;
   logic        unused_n;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk(clk), .rst(rst), .IWord(IWord), .IValid(IValid), .BEQ(BEQ), .BLT(BLT),
      .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWEn(RegWEn),
      .MemReq(MemReq), .MemRW(MemRW), .BrUn(BrUn), .ASel(ASel), .BSel(BSel),
      .PCSelect(PCSelect), .Illegal(Illegal), .ImmSel(ImmSel), .WBSel(WBSel),
      .ALUOP(ALUOP), .State(State)
   );

   multicycle_control_unit #(.EN_SLT(0), .EN_JUMP(0), .MEM_TIMEOUT(15)) dut_noslt (
      .clk(clk), .rst(rst), .IWord(IWord), .IValid(IValid), .BEQ(BEQ), .BLT(BLT),
      .MemReady(MemReady), .PCWrite(n_pcw), .IRWrite(n_irw), .RegWEn(n_rwe),
      .MemReq(n_mrq), .MemRW(n_mrw), .BrUn(n_bru), .ASel(n_asel), .BSel(n_bsel),
      .PCSelect(n_pcs), .Illegal(n_ill), .ImmSel(n_imm), .WBSel(n_wb),
      .ALUOP(n_alu), .State(n_state)
   );

   assign unused_n = ^{n_pcw, n_irw, n_rwe, n_mrq, n_mrw, n_bru, n_asel, n_bsel, n_pcs, n_imm, n_wb};

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] w);
      IWord  = w;
      IValid = 1'b1;
      tick();
      IValid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; IWord = 32'h0; IValid = 1'b0; BEQ = 1'b0; BLT = 1'b0; MemReady = 1'b0;
      tick(); tick();
      // reset state
      check_val("rst_state",   State, 3'd0);
      check_val("rst_ir",      dut.ir_reg, 32'h0000_0013);
      check_val("rst_wait",    dut.wait_cnt_reg, 8'd0);
      check_val("rst_strobes", {PCWrite, IRWrite, RegWEn, MemReq, MemRW, BrUn, ASel, BSel, PCSelect, Illegal}, 10'd0);
      check_val("rst_fields",  {ImmSel, WBSel, ALUOP}, 9'd0);
      rst = 1'b0;
      tick(); tick();
      check_val("fetch_hold_state", State, 3'd0);
      check_val("fetch_hold_irw",   IRWrite, 1'b0);
      $display("txn reset/idle done");

      // ADD x3,x1,x2
      fetch(32'h0020_81B3);
      check_val("add_decode", State, 3'd1);
      check_val("add_irw",    IRWrite, 1'b1);
      tick();
      check_val("add_exec",   State, 3'd2);
      check_val("add_aluop",  ALUOP, 4'd4);
      check_val("add_bsel",   BSel, 1'b0);
      check_val("add_irw_off", IRWrite, 1'b0);
      tick();
      check_val("add_wb",     State, 3'd4);
      check_val("add_regwen", RegWEn, 1'b1);
      check_val("add_wbsel",  WBSel, 2'd1);
      check_val("add_pcw",    PCWrite, 1'b1);
      tick();
      check_val("add_fetch",  State, 3'd0);
      check_val("add_regwen_off", RegWEn, 1'b0);
      $display("txn ADD x3,x1,x2 done");

      // LW x5,8(x1), MemReady low for 3 MEM cycles
      fetch(32'h0080_A283);
      tick();
      check_val("lw_exec_alu",  ALUOP, 4'd4);
      check_val("lw_exec_bsel", BSel, 1'b1);
      check_val("lw_exec_imm",  ImmSel, 3'd0);
      tick();
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (State == 3'd4) break;
         if (State == 3'd3 && MemReq && !MemRW) n++;
         MemReady = (n >= 4);
         tick();
      end
      MemReady = 1'b0;
      check_val("lw_memreq_cycles", n, 4);
      check_val("lw_wb_state", State, 3'd4);
      check_val("lw_wbsel",    WBSel, 2'd0);
      check_val("lw_regwen",   RegWEn, 1'b1);
      check_val("lw_memreq_off", MemReq, 1'b0);
      tick();
      check_val("lw_fetch", State, 3'd0);
      $display("txn LW x5,8(x1) done");

      // BGEU x1,x2,8 with BLT=1 (not taken) then BLT=0 (taken)
      for (int k = 0; k < 2; k++) begin
         BEQ = 1'b0;
         BLT = (k == 0);
         fetch(32'h0020_F463);
         tick();
         check_val("bgeu_exec",   State, 3'd2);
         check_val("bgeu_brun",   BrUn, 1'b1);
         check_val("bgeu_pcsel",  PCSelect, (k == 0) ? 1'b0 : 1'b1);
         check_val("bgeu_pcw",    PCWrite, 1'b1);
         check_val("bgeu_ctl",    {ASel, BSel, ImmSel, ALUOP, RegWEn}, {1'b1, 1'b1, 3'd2, 4'd4, 1'b0});
         tick();
         check_val("bgeu_fetch",  State, 3'd0);
         check_val("bgeu_regwen", RegWEn, 1'b0);
         $display("txn BGEU BLT=%0d done", BLT);
      end
      BLT = 1'b0;

      // SLT x3,x1,x2: legal on dut, trap on dut_noslt
      fetch(32'h0020_A1B3);
      tick();
      check_val("slt_exec",    State, 3'd2);
      check_val("slt_aluop",   ALUOP, 4'd9);
      check_val("noslt_trap",  n_state, 3'd5);
      check_val("noslt_ill",   n_ill, 1'b1);
      check_val("noslt_alu",   n_alu, 4'd0);
      tick(); tick();
      check_val("slt_fetch",   State, 3'd0);
      $display("txn SLT x3,x1,x2 done");

      // ADDI x0,x0,1 with IWord changed during EXEC
      fetch(32'h0010_0013);
      tick();
      check_val("addi_aluop",  ALUOP, 4'd4);
      check_val("addi_imm",    {BSel, ImmSel}, {1'b1, 3'd0});
      IWord = 32'h4020_81B3;
      tick();
      check_val("addi_wb",       State, 3'd4);
      check_val("addi_regwen",   RegWEn, 1'b0);
      check_val("addi_alu_hold", ALUOP, 4'd4);
      check_val("addi_pcw",      PCWrite, 1'b1);
      tick();
      $display("txn ADDI x0,x0,1 done");

      // JAL x1,0
      fetch(32'h0000_00EF);
      tick();
      check_val("jal_exec", {ImmSel, ASel, PCSelect}, {3'd4, 1'b1, 1'b1});
      tick();
      check_val("jal_wb",   {WBSel, PCSelect, RegWEn, PCWrite}, {2'd2, 1'b1, 1'b1, 1'b1});
      tick();
      $display("txn JAL x1,0 done");

      // ADD with illegal funct7 0x01
      fetch(32'h0220_81B3);
      tick();
      check_val("badf7_trap", State, 3'd5);
      check_val("badf7_ill",  Illegal, 1'b1);
      tick(); tick();
      check_val("badf7_hold", {State, Illegal, MemReq, RegWEn, PCWrite}, {3'd5, 1'b1, 1'b0, 1'b0, 1'b0});
      $display("txn illegal funct7 done");
      do_reset();
      check_val("post_rst_ill", Illegal, 1'b0);

      // SW x2,4(x1) with MemReady never high
      fetch(32'h0020_A223);
      tick();
      check_val("sw_exec_imm", ImmSel, 3'd1);
      tick();
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (State == 3'd5) break;
         if (State == 3'd3 && MemReq && MemRW) n++;
         tick();
      end
      check_val("sw_mem_cycles", n, 15);
      check_val("sw_trap",     State, 3'd5);
      check_val("sw_trap_out", {Illegal, MemReq, RegWEn, PCWrite, IRWrite}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      tick(); tick(); tick();
      check_val("sw_trap_hold", {State, Illegal, MemReq}, {3'd5, 1'b1, 1'b0});
      $display("txn SW timeout done");
      do_reset();

      // SW with reset asserted mid-MEM
      fetch(32'h0020_A223);
      tick(); tick();
      check_val("swr_mem",    {State, MemReq}, {3'd3, 1'b1});
      #2 rst = 1'b1;
      #1;
      check_val("swr_async_memreq", MemReq, 1'b0);
      check_val("swr_async_state",  State, 3'd0);
      tick();
      rst = 1'b0;
      $display("txn SW async reset done");

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Parameters
REQ-001 The block SHALL have parameter EN_SLT, default 1, meaning 1 decodes SLT/SLTI/SLTU/SLTIU and 0 flags them illegal.
REQ-002 The block SHALL have parameter EN_JUMP, default 1, meaning 1 decodes LUI/AUIPC/JAL/JALR and 0 flags them illegal.
REQ-003 The block SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum MEM wait cycles before a trap (range 1..255).

Interface
REQ-004 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset; one clock; reset is asynchronous and active-high.
REQ-006 The block SHALL have port IWord, input, 32 bits, the instruction; it is sampled only in FETCH when IValid=1.
REQ-007 The block SHALL have port IValid, input, 1 bit, fetch data valid.
REQ-008 The block SHALL have ports BEQ and BLT, inputs, 1 bit each, the branch comparator results.
REQ-009 The block SHALL have port MemReady, input, 1 bit, data-memory handshake acknowledge.
REQ-010 The block SHALL have outputs PCWrite, IRWrite, RegWEn, MemReq, MemRW, BrUn, ASel, BSel, PCSelect and Illegal, 1 bit each.
REQ-011 The block SHALL have outputs ImmSel[2:0] (0=I, 1=S, 2=B, 3=U, 4=J), WBSel[1:0] (0=mem, 1=ALU, 2=PC+4), ALUOP[3:0] and State[2:0].

Function
REQ-012 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5; State SHALL show the current state.
REQ-013 FETCH SHALL hold while IValid=0; on IValid=1 it SHALL pulse IRWrite for one cycle, latch IWord into an internal IR, and go to DECODE.
REQ-014 All decode in DECODE and later states SHALL use only the latched IR, never the live IWord.
REQ-015 DECODE SHALL go to TRAP for an unsupported opcode or funct3/funct7; otherwise it SHALL go to EXEC.
REQ-016 The ALUOP encoding SHALL be AND=1, OR=2, XOR=3, ADD=4, SUB=5, SRL=6, SLL=7, SRA=8, SLT=9, SLTU=10, PASSB=11.
REQ-017 R-type: funct7 SHALL be 0x00, or 0x20 only with ADD/SRL (giving SUB/SRA); any other funct7 SHALL be illegal; control SHALL be BSel=0, WBSel=1.
REQ-018 I-ALU: SRAI SHALL be selected by IR[30]; SLLI/SRLI with IR[31:25] not in {0x00, 0x20-for-SRAI} SHALL be illegal; control SHALL be BSel=1, ImmSel=0.
REQ-019 Load/store: ALUOP SHALL be ADD, BSel=1, ImmSel 0 for loads and 1 for stores; EXEC SHALL go to MEM.
REQ-020 MEM SHALL hold MemReq=1 (MemRW=1 for store) until MemReady=1; loads SHALL then go to WB and stores to FETCH with PCWrite=1.
REQ-021 An 8-bit wait counter SHALL clear on MEM entry; if MemReady is still 0 after MEM_TIMEOUT cycles the FSM SHALL go to TRAP.
REQ-022 Branch: EXEC SHALL set PCSelect from funct3 (0:BEQ, 1:~BEQ, 4:BLT, 5:~BLT, 6:BLT with BrUn=1, 7:~BLT with BrUn=1), with ASel=1, BSel=1, ImmSel=2, ALUOP=ADD, PCWrite=1, then go to FETCH; funct3 2 or 3 SHALL be illegal.
REQ-023 LUI SHALL use ALUOP=PASSB, ImmSel=3; AUIPC SHALL use ASel=1, ImmSel=3, ALUOP=ADD; JAL/JALR SHALL use WBSel=2 and PCSelect=1 (ImmSel=4 with ASel=1 for JAL; ImmSel=0 with ASel=0 for JALR).
REQ-024 WB SHALL assert RegWEn=1 and PCWrite=1 for one cycle, then go to FETCH; RegWEn SHALL never be asserted when IR[11:7]=0.
REQ-025 Stores and branches SHALL never assert RegWEn.
REQ-026 TRAP SHALL assert Illegal=1 and hold all write strobes and MemReq at 0; TRAP SHALL be left only by reset.
REQ-027 Outputs SHALL be registered on the rising clock edge or decoded from State/IR only; no output SHALL depend combinationally on IWord.

Reset
REQ-028 While rst=1 the FSM SHALL be in FETCH and IR=0x00000013 (NOP).
REQ-029 While rst=1, all 1-bit outputs, ALUOP, ImmSel, WBSel and the wait counter SHALL be 0.
REQ-030 Reset asserted mid-MEM SHALL drop MemReq in the same cycle, asynchronously.

Verification
REQ-031 ADD x3,x1,x2 (0x002081B3) with IValid=1 -> states 0,1,2,4,0; ALUOP=4, WBSel=1, one-cycle RegWEn in WB.
REQ-032 LW x5,8(x1) with MemReady held low 3 cycles -> MemReq high for exactly 4 MEM cycles, then WB with WBSel=0.
REQ-033 SW with MemReady never high and MEM_TIMEOUT=15 -> TRAP entered after 15 MEM cycles; Illegal=1 and MemReq=0 until rst.
REQ-034 BGEU with BEQ=0, BLT=1 -> BrUn=1, PCSelect=0; same instruction with BLT=0 -> PCSelect=1.
REQ-035 SLT with EN_SLT=0 -> TRAP from DECODE; with EN_SLT=1 -> ALUOP=9.
REQ-036 ADDI x0,x0,1 -> WB reached with RegWEn=0; IWord changed during EXEC -> ALUOP unchanged.
